// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and memory freeze.
// Outputs are combinational from the current state and inputs, so every hazard is handled in the same cycle.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_hold,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } state_e;

  localparam logic [2:0] REM_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  rem_q, rem_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        load_use;

  assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rem_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      rem_d       = 3'd0;
    end else begin
      case (state_q)
        FLUSH: begin
          // A memory freeze suspends the flush without consuming any of its cycles.
          if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
          end else begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (rem_q <= 3'd1) begin
              state_d = RUN;
              rem_d   = 3'd0;
            end else begin
              state_d = FLUSH;
              rem_d   = rem_q - 3'd1;
            end
          end
        end
        RUN, STALL, MEMWAIT: begin
          if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_d    = MEMWAIT;
          end else if (br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              rem_d   = REM_INIT;
            end else begin
              state_d = RUN;
              rem_d   = 3'd0;
            end
          end else if (load_use && (state_q != STALL)) begin
            // STALL masks load_use so a single load inserts exactly one bubble.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = STALL;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, range 1..4; total cycles of flush per taken branch.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 idex_mem_read  input  1  MemRead control bit currently held in the ID/EX register.
REQ-008 idex_rt  input  5  rt address currently held in the ID/EX register.
REQ-009 br_taken  input  1  branch resolved taken this cycle.
REQ-010 mem_busy  input  1  data memory requests a full pipeline freeze.
REQ-011 pc_write  output  1  PC load enable.
REQ-012 ifid_write  output  1  IF/ID register load enable.
REQ-013 ifid_flush  output  1  zero IF/ID contents at next edge.
REQ-014 idex_bubble  output  1  load all-zero control bits into ID/EX at next edge.
REQ-015 pipe_hold  output  1  freeze ID/EX and all downstream pipeline registers.
REQ-016 state  output  2  current FSM state (RUN=0, STALL=1, FLUSH=2, MEMWAIT=3).
REQ-017 stall_cnt  output  16  count of cycles with pc_write=0.
REQ-018 flush_cnt  output  16  count of cycles with ifid_flush=1.

Function
REQ-019 load_use SHALL be idex_mem_read & (idex_rt!=0) & ((idex_rt==id_rs) | (id_uses_rt & idex_rt==id_rt)); combinational.
REQ-020 Default (normal-flow) outputs SHALL be pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_hold=0.
REQ-021 Priority in RUN and STALL SHALL be mem_busy > br_taken > load_use, evaluated combinationally in the same cycle.
REQ-022 RUN, mem_busy=1: pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0; next state MEMWAIT.
REQ-023 MEMWAIT, mem_busy=1: same outputs as REQ-022; remain MEMWAIT.
REQ-024 MEMWAIT, mem_busy=0: outputs and next state exactly as RUN for the current inputs (no dead cycle).
REQ-025 RUN, br_taken=1, mem_busy=0: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; next FLUSH with remaining count FLUSH_CYCLES-1, or stay RUN if FLUSH_CYCLES=1.
REQ-026 FLUSH: Moore outputs ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; decrement remaining count; return to RUN when it reaches 0; br_taken and load_use ignored; mem_busy=1 SHALL freeze count and state with pipe_hold=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
REQ-027 RUN, load_use=1, no higher-priority event: pc_write=0, ifid_write=0, idex_bubble=1; next STALL.
REQ-028 STALL: as RUN but load_use suppressed (exactly one bubble per load); next RUN unless REQ-022/REQ-025 transitions apply.
REQ-029 stall_cnt SHALL increment on each edge where pc_write=0 and reset=0; flush_cnt on each edge where ifid_flush=1 and reset=0; both saturate at 0xFFFF.
REQ-030 Total flush cycles per taken branch SHALL equal FLUSH_CYCLES, excluding mem_busy freeze cycles.

Reset
REQ-031 reset=1 SHALL immediately force state=RUN, flush remaining count=0, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-032 While reset=1, outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0; counters do not count.
REQ-033 Reset asserted mid-FLUSH or mid-MEMWAIT SHALL abandon the operation; first cycle after release is RUN with normal-flow evaluation.

Verification
REQ-034 idex_mem_read=1, idex_rt=5, id_rs=5 -> same cycle pc_write=0, idex_bubble=1; next cycle state=STALL, normal outputs; stall_cnt=1.
REQ-035 idex_mem_read=1, idex_rt=0, id_rs=0 -> no stall; idex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-036 FLUSH_CYCLES=2, br_taken pulse 1 cycle -> ifid_flush=1 for exactly 2 cycles, state RUN->FLUSH->RUN, flush_cnt=2.
REQ-037 br_taken=1 and mem_busy=1 for 3 cycles, then mem_busy=0 with br_taken=1 -> pipe_hold=1 for 3 cycles, stall_cnt=3, then flush begins; load_use simultaneous with br_taken -> flush only, no STALL.
REQ-038 mem_busy=1 during FLUSH second cycle for 2 cycles -> flush suspended, resumes, total ifid_flush cycles=2.
REQ-039 reset asserted mid-MEMWAIT between edges -> state=0, counters=0 without a clock edge; reset outputs per REQ-032.
